// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared operation encoding and pointer-width helper for the sync FIFO
package sync_fifo_pkg;

    typedef enum logic [1:0] {FIFO_IDLE, FIFO_WR, FIFO_RD, FIFO_RW} fifo_op_e;

    function automatic int ptr_w(int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: FIFO storage; read port registered, or combinational when SYNC_FIFO_FWFT_EN is defined
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AW         = ptr_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // store accepted writes; contents are never cleared
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

`ifdef SYNC_FIFO_FWFT_EN
    logic unused_ok;
    assign unused_ok = rst ^ re_i;
    assign rdata_o   = mem_q[raddr_i];
`else
    logic [DATA_WIDTH-1:0] rdata_q;

    // capture the head word on an accepted read, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with count, threshold and sticky error flags (SYNC_FIFO_FWFT_EN selects fall-through reads)
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    w_en,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    r_en,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = ptr_w(DEPTH);

    typedef logic [AW:0] ptr_t;

    localparam ptr_t ONE = ptr_t'(1);
    localparam ptr_t AF  = ptr_t'(AF_LEVEL);
    localparam ptr_t AE  = ptr_t'(AE_LEVEL);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_ctrl: DEPTH must be a power of two >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("sync_fifo_ctrl: AF_LEVEL out of range 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_ctrl: AE_LEVEL out of range 0..DEPTH-1");
    end

    ptr_t     wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
    logic     full_q, full_d, empty_q, empty_d, af_q, af_d, ae_q, ae_d;
    logic     ovf_q, ovf_d, udf_q, udf_d;
    logic     rd_ok, wr_ok;
    fifo_op_e op;

    // decode this cycle's operation; flags come from next-state pointers so they track count
    always_comb begin
        rd_ok   = r_en & ~empty_q;
        wr_ok   = w_en & (~full_q | rd_ok);
        op      = flush ? FIFO_IDLE : fifo_op_e'({rd_ok, wr_ok});
        wptr_d  = (op == FIFO_WR || op == FIFO_RW) ? wptr_q + ONE : (flush ? '0 : wptr_q);
        rptr_d  = (op == FIFO_RD || op == FIFO_RW) ? rptr_q + ONE : (flush ? '0 : rptr_q);
        count_d = flush ? '0 : op == FIFO_WR ? count_q + ONE : op == FIFO_RD ? count_q - ONE : count_q;
        ovf_d   = ~flush & (ovf_q | (w_en & ~wr_ok));
        udf_d   = ~flush & (udf_q | (r_en & ~rd_ok));
        empty_d = wptr_d == rptr_d;
        full_d  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
        af_d    = count_d >= AF;
        ae_d    = count_d <= AE;
    end

    // state register; reset leaves the FIFO empty with errors cleared
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (op == FIFO_WR || op == FIFO_RW),
        .waddr_i (wptr_q[AW-1:0]),
        .wdata_i (data_in),
        .re_i    (op == FIFO_RD || op == FIFO_RW),
        .raddr_i (rptr_q[AW-1:0]),
        .rdata_o (data_out)
    );

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: scoreboard bench for sync_fifo_ctrl, directed scenarios plus random traffic
module tb_sync_fifo_ctrl;

    localparam int DW = 8;
    localparam int DEPTH = 8;
    localparam int AF = 6;
    localparam int AE = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          w_en = 1'b0;
    logic          r_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0]    count;

    int            n_chk = 0;
    int            n_fail = 0;
    logic [DW-1:0] sb [$];
    int            m_cnt = 0;
    bit            m_ovf = 0;
    bit            m_udf = 0;

    sync_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .w_en         (w_en),
        .data_in      (data_in),
        .r_en         (r_en),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, ":count"}, 32'(count), 32'(m_cnt));
        chk({tag, ":empty"}, 32'(empty), 32'(m_cnt == 0));
        chk({tag, ":full"}, 32'(full), 32'(m_cnt == DEPTH));
        chk({tag, ":almost_full"}, 32'(almost_full), 32'(m_cnt >= AF));
        chk({tag, ":almost_empty"}, 32'(almost_empty), 32'(m_cnt <= AE));
        chk({tag, ":overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ":underflow"}, 32'(underflow), 32'(m_udf));
    endtask

    // one clock of stimulus; the reference model decides acceptance from occupancy alone
    task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r, input bit f, input string tag);
        bit rd, wr;
        @(negedge clk);
        w_en = w;
        data_in = d;
        r_en = r;
        flush = f;
        rd = r && m_cnt > 0;
        wr = w && (m_cnt < DEPTH || rd);
        @(posedge clk);
        #1;
        if (f) begin
            m_cnt = 0;
            m_ovf = 0;
            m_udf = 0;
            sb.delete();
        end else begin
            m_ovf = m_ovf | (w && !wr);
            m_udf = m_udf | (r && !rd);
            m_cnt = m_cnt + int'(wr) - int'(rd);
            if (wr) sb.push_back(d);
        end
        chk_flags(tag);
    endtask

    // monitor: pops the scoreboard on every accepted read and checks the word the DUT presents
    initial begin
        bit hs;
        forever begin
            @(negedge clk);
            #2;
            hs = !rst && !flush && r_en && !empty;
`ifdef SYNC_FIFO_FWFT_EN
            if (!rst && !empty) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL fwft_head: DUT not empty, no expected word");
                end else chk("fwft_head", 32'(data_out), 32'(sb[0]));
            end
`endif
            @(posedge clk);
            #2;
            if (hs) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rd_pop: read accepted with no expected word");
                end else begin
`ifdef SYNC_FIFO_FWFT_EN
                    void'(sb.pop_front());
`else
                    chk("rd_data", 32'(data_out), 32'(sb.pop_front()));
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_flags("reset");
`ifndef SYNC_FIFO_FWFT_EN
        chk("reset:data_out", 32'(data_out), 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) cyc(1, DW'(i), 0, 0, "fill");
        cyc(1, 8'h55, 0, 0, "overflow");
        for (int i = 0; i < 8; i++) cyc(0, '0, 1, 0, "readback");
        for (int i = 0; i < 8; i++) cyc(1, DW'(8'h10 + i), 0, 0, "refill");
        for (int i = 0; i < 20; i++) cyc(1, DW'(8'h80 + i), 1, 0, "full_rw");
        for (int i = 0; i < 8; i++) cyc(0, '0, 1, 0, "drain");
        cyc(1, 8'hAA, 1, 0, "empty_rw");
        cyc(0, '0, 1, 0, "read_aa");
        for (int i = 0; i < 4; i++) cyc(1, DW'(8'hC0 + i), 0, 0, "four");
        cyc(1, 8'h77, 0, 1, "flush");
        cyc(0, '0, 0, 0, "idle");
        cyc(1, 8'h3C, 0, 0, "fwft_wr");
        cyc(0, '0, 0, 0, "fwft_hold");
        cyc(0, '0, 1, 0, "fwft_pop");
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 99) < (i < 200 ? 65 : 35), DW'($urandom),
                $urandom_range(0, 99) < (i < 200 ? 35 : 65), $urandom_range(0, 49) == 0, "random");
        end
        cyc(0, '0, 0, 0, "final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Single-clock, parametrised FIFO that succeeds the team's dual-pointer FIFO memory. It adds occupancy count, programmable almost-full and almost-empty flags, sticky overflow and underflow flags, a synchronous flush, and same-cycle read/write when full. It sits between producer and consumer stages of one clock domain and owns both pointers internally, so no external pointer logic is needed.

## Interface
- `DATA_WIDTH`, default 8: word width in bits.
- `DEPTH`, default 8: number of entries; must be a power of two and at least 2.
- `AF_LEVEL`, default `DEPTH-2`: `almost_full` asserts when `count >= AF_LEVEL`.
- `AE_LEVEL`, default 2: `almost_empty` asserts when `count <= AE_LEVEL`.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `flush`  in  1  synchronous clear of pointers, count and error flags.
- `w_en`  in  1  write request.
- `data_in`  in  DATA_WIDTH  write data.
- `r_en`  in  1  read request.
- `data_out`  out  DATA_WIDTH  read data.
- `full`, `empty`  out  1 each  occupancy flags.
- `almost_full`, `almost_empty`  out  1 each  threshold flags.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`, `underflow`  out  1 each  sticky error flags.

## Operation
- Pointers `wptr` and `rptr` are each $clog2(DEPTH)+1 bits. The MSB is the wrap bit.
  - `empty` = (`wptr == rptr`).
  - `full` = (MSBs differ and the low bits are equal).
  - The low bits index the memory. Increments wrap naturally at 2^(PTR_WIDTH+1).
- `rd_ok` = `r_en & !empty`.
- `wr_ok` = `w_en & (!full | rd_ok)`. A write to a full FIFO is accepted when a valid read happens in the same cycle.
- Write to an empty FIFO with simultaneous `r_en`: the write is accepted and the read is rejected (underflow).
- `count` update:
  - +1 on `wr_ok & !rd_ok`.
  - −1 on `rd_ok & !wr_ok`.
  - Unchanged otherwise.
- All flags are registered and derived from next-state values, so they are valid in the same cycle as `count`.
- `overflow` sets on `w_en & !wr_ok`. `underflow` sets on `r_en & !rd_ok`. Both stay set until `rst` or `flush`.
- `flush` zeroes pointers, `count`, `overflow` and `underflow`.
  - `flush` does not clear memory contents or `data_out`.
  - `flush` takes priority over a same-cycle `w_en`/`r_en`; those requests are dropped and no error flag is set.
- `rst` has priority over `flush`.
- Thresholds: `AF_LEVEL` must be in 1..DEPTH and `AE_LEVEL` in 0..DEPTH-1. An out-of-range value is an elaboration error (`$error`).

## Timing
- Reset values:
  - `count`, `full`, `almost_full`, `overflow`, `underflow`, `data_out` = 0.
  - `empty` = 1; `almost_empty` = 1.
- Standard mode: `data_out` is updated at the edge that accepts `rd_ok`, so it is valid the cycle after `r_en`. Otherwise it holds its last value.
- Write to readable latency: a word written at edge N can be read with `r_en` high in cycle N (after that edge). `empty` falls at edge N.
- Full throughput: one write and one read per cycle at any occupancy, including full. An empty FIFO accepts only the write.

## Configuration
- `SYNC_FIFO_FWFT_EN` defined: first-word-fall-through mode.
  - `data_out` always shows the head entry whenever `!empty`, read combinationally from the memory at `rptr`.
  - `r_en` acts as a pop acknowledge.
  - The first word is visible the cycle after it is written.
  - `data_out` is don't-care while `empty`; the bench checks it only when `!empty`.
- Undefined: standard registered-read mode as described in Timing.
- Flags, count and error behaviour are identical in both modes.

## Structure
- `sync_fifo_pkg` holds:
  - `function automatic int ptr_w(int depth)` returning $clog2(depth).
  - `typedef enum logic [1:0] {FIFO_IDLE, FIFO_WR, FIFO_RD, FIFO_RW} fifo_op_e`, used to decode the per-cycle operation that selects the count and pointer update.
- Sub-module `sync_fifo_ram`: DEPTH×DATA_WIDTH array with a synchronous write port and a read port. The read port is registered or combinational depending on the macro. The controller contains pointers, count and flags only.

## Test plan
- DEPTH=8, AF=6, AE=2:
  - After reset, write 0x01..0x08 on consecutive cycles → `full`=1 and `count`=8.
  - `almost_full` rises on the edge where count reaches 6.
  - `almost_empty` falls when count reaches 3.
- Full, then `w_en`=1 with 0x55 and `r_en`=0 → `overflow`=1, `count` stays 8, and the contents are unchanged on readback (0x01..0x08).
- Full, then `w_en` and `r_en` together for 20 cycles with incrementing data → `count` stays 8, pointers wrap at least twice, and the read order is preserved.
- Empty, then `r_en`=1 and `w_en`=1 with 0xAA in the same cycle → `underflow`=1, `count`=1, and the next read returns 0xAA.
- Four words stored, `overflow` set, then `flush` pulsed with `w_en`=1 → `count`=0, `empty`=1, `overflow`=0, and the write is dropped.
- FWFT build, write 0x3C to an empty FIFO → `data_out`=0x3C the following cycle with `r_en` never asserted. `r_en`=1 then gives `empty`=1 on the next edge.
